// File: rtl/bonus_pkg.sv
// Shared types and helpers for the falling-bonus pool: bonus kinds,
// fixed-point sizing and small bit-vector utilities over the slot masks.
package bonus_pkg;

  typedef enum logic [1:0] {
    BONUS_WIDE  = 2'd0,
    BONUS_LIFE  = 2'd1,
    BONUS_SLOW  = 2'd2,
    BONUS_MULTI = 2'd3
  } bonus_type_t;

  localparam int FRAC_BITS_DEFAULT = 6;
  localparam int PIX_W             = 11;
  localparam int MAX_SLOTS         = 8;

  // One spare integer bit above the pixel range so Y can run past the floor.
  function automatic int fp_width(input int frac_bits);
    return PIX_W + frac_bits + 1;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [MAX_SLOTS-1:0] v);
    lowest_set = '0;
    for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

  function automatic logic [3:0] pop_count(input logic [MAX_SLOTS-1:0] v);
    pop_count = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      pop_count = pop_count + 4'(v[i]);
    end
  endfunction

endpackage

// File: rtl/bonus_slot.sv
// One falling bonus: holds position/speed/kind, applies the per-frame fall
// and resolves clear > catch > miss > move for its own retirement.
module bonus_slot
  import bonus_pkg::*;
#(
  parameter int FRAC_BITS  = FRAC_BITS_DEFAULT,
  parameter int FLOOR_Y    = 430,
  parameter int INIT_SPEED = 50,
  parameter int ACCEL      = 2,
  parameter int MAX_SPEED  = 256
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [PIX_W-1:0] load_x,
  input  logic [PIX_W-1:0] load_y,
  input  bonus_type_t      load_type,
  input  logic             startOfFrame,
  input  logic             collision,
  input  logic             clear,
  output logic             active,
  output logic [PIX_W-1:0] pix_x,
  output logic [PIX_W-1:0] pix_y,
  output bonus_type_t      slot_type,
  output logic             caught,
  output logic             missed
);

  localparam int FP_W  = fp_width(FRAC_BITS);
  localparam int SPD_W = $clog2(MAX_SPEED + 1);

  typedef logic [SPD_W:0] spd_ext_t;

  localparam logic [FP_W-1:0] FLOOR_FP = FP_W'(FLOOR_Y << FRAC_BITS);
  localparam spd_ext_t        MAX_EXT  = spd_ext_t'(MAX_SPEED);

  logic             active_q;
  logic [PIX_W-1:0] x_q;  // X never moves, so its fraction is always zero
  logic [FP_W-1:0]  y_q;
  logic [SPD_W-1:0] spd_q;
  bonus_type_t      type_q;

  logic             past_floor;
  logic             move;
  spd_ext_t         spd_sum;
  logic [SPD_W-1:0] spd_next;

  assign past_floor = y_q > FLOOR_FP;
  assign caught     = active_q && collision && !clear;
  assign missed     = active_q && startOfFrame && !clear && !collision && past_floor;
  assign move       = active_q && startOfFrame && !clear && !collision && !past_floor;

  assign spd_sum  = spd_ext_t'(spd_q) + spd_ext_t'(ACCEL);
  assign spd_next = (spd_sum > MAX_EXT) ? SPD_W'(MAX_SPEED) : spd_sum[SPD_W-1:0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      spd_q    <= '0;
      type_q   <= BONUS_WIDE;
    end else if (clear || caught || missed) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      spd_q    <= '0;
      type_q   <= BONUS_WIDE;
    end else if (load) begin
      active_q <= 1'b1;
      x_q      <= load_x;
      y_q      <= FP_W'(load_y) << FRAC_BITS;
      spd_q    <= SPD_W'(INIT_SPEED);
      type_q   <= load_type;
    end else if (move) begin
      // New Y uses the speed from before this frame's acceleration.
      y_q   <= y_q + FP_W'(spd_q);
      spd_q <= spd_next;
    end
  end

  assign active    = active_q;
  assign pix_x     = x_q;
  assign pix_y     = y_q[FRAC_BITS +: PIX_W];
  assign slot_type = type_q;

endmodule

// File: rtl/bonus_drop_pool.sv
// Pool of falling bonus slots: allocates spawn requests to the lowest free
// slot, detects level changes, and registers catch/miss/drop events.
module bonus_drop_pool
  import bonus_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int FRAC_BITS  = FRAC_BITS_DEFAULT,
  parameter int FLOOR_Y    = 430,
  parameter int INIT_SPEED = 50,
  parameter int ACCEL      = 2,
  parameter int MAX_SPEED  = 256
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   spawnReq,
  input  logic [10:0]            spawnX,
  input  logic [10:0]            spawnY,
  input  logic [1:0]             spawnType,
  output logic                   spawnAck,
  output logic                   spawnDrop,
  input  logic [NUM_SLOTS-1:0]   slotCollision,
  input  logic [1:0]             lvl,
  output logic [NUM_SLOTS*11-1:0] topLeftX,
  output logic [NUM_SLOTS*11-1:0] topLeftY,
  output logic [NUM_SLOTS*2-1:0] slotType,
  output logic [NUM_SLOTS-1:0]   activeMask,
  output logic [NUM_SLOTS-1:0]   caughtMask,
  output logic                   caughtValid,
  output logic [1:0]             caughtType,
  output logic [7:0]             missCount
);

  logic [NUM_SLOTS-1:0] active, caught, missed, load;
  bonus_type_t          slot_types [NUM_SLOTS];
  logic [1:0]           lvl_d;
  logic                 lvl_chg;
  logic [2:0]           free_idx;
  bonus_type_t          caught_type_c;
  logic [8:0]           miss_sum;

  // Spawn handshake: spawnReq is a single-cycle offer with no retry;
  // spawnAck in the same cycle means the offer was taken, otherwise it is
  // dropped and spawnDrop reports it one cycle later.
  assign lvl_chg  = lvl != lvl_d;
  assign spawnAck = spawnReq && !(&active) && !lvl_chg;
  assign free_idx = lowest_set(MAX_SLOTS'(~active));

  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load[i] = spawnAck && (free_idx == 3'(i));
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [10:0] px, py;

    bonus_slot #(
      .FRAC_BITS (FRAC_BITS),
      .FLOOR_Y   (FLOOR_Y),
      .INIT_SPEED(INIT_SPEED),
      .ACCEL     (ACCEL),
      .MAX_SPEED (MAX_SPEED)
    ) u_slot (
      .clk         (clk),
      .resetN      (resetN),
      .load        (load[g]),
      .load_x      (spawnX),
      .load_y      (spawnY),
      .load_type   (bonus_type_t'(spawnType)),
      .startOfFrame(startOfFrame),
      .collision   (slotCollision[g]),
      .clear       (lvl_chg),
      .active      (active[g]),
      .pix_x       (px),
      .pix_y       (py),
      .slot_type   (slot_types[g]),
      .caught      (caught[g]),
      .missed      (missed[g])
    );

    assign topLeftX[11*g +: 11] = px;
    assign topLeftY[11*g +: 11] = py;
    assign slotType[2*g +: 2]   = slot_types[g];
  end

  // Scan high to low so the lowest caught index wins.
  always_comb begin
    caught_type_c = BONUS_WIDE;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (caught[i]) caught_type_c = slot_types[i];
    end
  end

  assign miss_sum = {1'b0, missCount} + 9'(pop_count(MAX_SLOTS'(missed)));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lvl_d       <= '0;
      spawnDrop   <= 1'b0;
      caughtMask  <= '0;
      caughtValid <= 1'b0;
      caughtType  <= '0;
      missCount   <= '0;
    end else begin
      lvl_d       <= lvl;
      spawnDrop   <= spawnReq && !spawnAck;
      caughtMask  <= caught;
      caughtValid <= |caught;
      caughtType  <= caught_type_c;
      missCount   <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end
  end

  assign activeMask = active;

endmodule

// File: tb/tb_bonus_drop_pool.sv
// Directed bench for bonus_drop_pool: spawn, fall, speed cap, pool full,
// catches, misses with saturation, level change and async reset.
module tb_bonus_drop_pool;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        spawnReq;
  logic [10:0] spawnX, spawnY;
  logic [1:0]  spawnType;
  logic [3:0]  slotCollision;
  logic [1:0]  lvl;

  logic        spawnAck, spawnDrop, caughtValid;
  logic [43:0] topLeftX, topLeftY;
  logic [7:0]  slotType;
  logic [3:0]  activeMask, caughtMask;
  logic [1:0]  caughtType;
  logic [7:0]  missCount;

  logic        c_spawnAck, c_spawnDrop, c_caughtValid;
  logic [43:0] c_topLeftX, c_topLeftY;
  logic [7:0]  c_slotType;
  logic [3:0]  c_activeMask, c_caughtMask;
  logic [1:0]  c_caughtType;
  logic [7:0]  c_missCount;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  bonus_drop_pool u_dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .spawnReq(spawnReq), .spawnX(spawnX), .spawnY(spawnY), .spawnType(spawnType),
    .spawnAck(spawnAck), .spawnDrop(spawnDrop), .slotCollision(slotCollision),
    .lvl(lvl), .topLeftX(topLeftX), .topLeftY(topLeftY), .slotType(slotType),
    .activeMask(activeMask), .caughtMask(caughtMask), .caughtValid(caughtValid),
    .caughtType(caughtType), .missCount(missCount)
  );

  bonus_drop_pool #(.MAX_SPEED(52)) u_dut_cap (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .spawnReq(spawnReq), .spawnX(spawnX), .spawnY(spawnY), .spawnType(spawnType),
    .spawnAck(c_spawnAck), .spawnDrop(c_spawnDrop), .slotCollision(slotCollision),
    .lvl(lvl), .topLeftX(c_topLeftX), .topLeftY(c_topLeftY), .slotType(c_slotType),
    .activeMask(c_activeMask), .caughtMask(c_caughtMask), .caughtValid(c_caughtValid),
    .caughtType(c_caughtType), .missCount(c_missCount)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] x_at(input int i);
    return topLeftX[11*i +: 11];
  endfunction

  function automatic logic [10:0] y_at(input int i);
    return topLeftY[11*i +: 11];
  endfunction

  function automatic logic [1:0] type_at(input int i);
    return slotType[2*i +: 2];
  endfunction

  // Scoreboard: every caught pulse must match the next expected kind.
  always @(negedge clk) begin
    if (resetN === 1'b1 && caughtValid === 1'b1) begin
      if (exp_q.size() == 0) check("catch_queue_nonempty", 32'(exp_q.size()), 32'd1);
      else check("catch_type_sb", 32'(caughtType), exp_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
  endtask

  task automatic spawn(input logic [10:0] x, input logic [10:0] y, input logic [1:0] t,
                       input logic sof, input logic exp_ack);
    spawnReq = 1'b1; spawnX = x; spawnY = y; spawnType = t; startOfFrame = sof;
    #1;
    check("spawn_ack", 32'(spawnAck), 32'(exp_ack));
    step();
    spawnReq = 1'b0; startOfFrame = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; spawnReq = 1'b0;
    spawnX = '0; spawnY = '0; spawnType = '0; slotCollision = '0; lvl = 2'd0;
    step(); step();
    check("rst_active", 32'(activeMask), 32'd0);
    check("rst_miss", 32'(missCount), 32'd0);
    check("rst_drop", 32'(spawnDrop), 32'd0);
    check("rst_caught", 32'(caughtValid), 32'd0);
    check("rst_pos", 32'(|{topLeftX, topLeftY}), 32'd0);
    resetN = 1'b1;
    step();

    // First spawn and fall
    spawn(11'd100, 11'd200, 2'd1, 1'b0, 1'b1);
    check("spawn_active", 32'(activeMask), 32'b0001);
    check("spawn_x0", 32'(x_at(0)), 32'd100);
    check("spawn_y0", 32'(y_at(0)), 32'd200);
    check("spawn_type0", 32'(type_at(0)), 32'd1);
    repeat (3) frame();
    check("fall3_y0", 32'(y_at(0)), 32'd202);
    repeat (7) frame();
    check("fall10_y0", 32'(y_at(0)), 32'd209);
    check("fall10_cap_y0", 32'(c_topLeftY[10:0]), 32'd208);

    // Fill the pool, then overflow
    spawn(11'd10, 11'd100, 2'd3, 1'b0, 1'b1);
    spawn(11'd20, 11'd100, 2'd0, 1'b0, 1'b1);
    spawn(11'd30, 11'd100, 2'd2, 1'b0, 1'b1);
    check("full_active", 32'(activeMask), 32'hF);
    check("full_x2", 32'(x_at(2)), 32'd20);
    spawn(11'd40, 11'd100, 2'd1, 1'b0, 1'b0);
    check("full_drop", 32'(spawnDrop), 32'd1);
    step();
    check("full_drop_end", 32'(spawnDrop), 32'd0);
    check("full_still", 32'(activeMask), 32'hF);

    // Catch slot 2, then reuse it
    exp_q.push_back(32'd0);
    slotCollision = 4'b0100;
    step();
    slotCollision = '0;
    check("catch2_mask", 32'(caughtMask), 32'b0100);
    check("catch2_valid", 32'(caughtValid), 32'd1);
    check("catch2_active", 32'(activeMask), 32'b1011);
    step();
    check("catch2_pulse_end", 32'(caughtValid), 32'd0);
    spawn(11'd77, 11'd100, 2'd0, 1'b0, 1'b1);
    check("reuse_active", 32'(activeMask), 32'hF);
    check("reuse_x2", 32'(x_at(2)), 32'd77);

    // Double catch with a frame in the same cycle
    exp_q.push_back(32'd3);
    slotCollision = 4'b0110;
    startOfFrame  = 1'b1;
    step();
    slotCollision = '0;
    startOfFrame  = 1'b0;
    check("dcatch_mask", 32'(caughtMask), 32'b0110);
    check("dcatch_valid", 32'(caughtValid), 32'd1);
    check("dcatch_type", 32'(caughtType), 32'd3);
    check("dcatch_active", 32'(activeMask), 32'b1001);
    check("dcatch_y0", 32'(y_at(0)), 32'd210);
    frame();
    check("dcatch_y3", 32'(y_at(3)), 32'd101);
    check("dcatch_y0b", 32'(y_at(0)), 32'd211);

    // Level change with spawn and collision in the same cycle
    lvl = 2'd1;
    spawnReq = 1'b1; spawnX = 11'd50; spawnY = 11'd50; spawnType = 2'd1;
    slotCollision = 4'b0001;
    #1;
    check("lvl_ack", 32'(spawnAck), 32'd0);
    step();
    spawnReq = 1'b0; slotCollision = '0;
    check("lvl_active", 32'(activeMask), 32'd0);
    check("lvl_drop", 32'(spawnDrop), 32'd1);
    check("lvl_caught", 32'(caughtValid), 32'd0);
    check("lvl_miss", 32'(missCount), 32'd0);

    // Miss at the floor; spawn cycle frame must not move the new slot
    spawn(11'd5, 11'd429, 2'd2, 1'b1, 1'b1);
    check("miss_y_spawn", 32'(y_at(0)), 32'd429);
    startOfFrame = 1'b1;
    slotCollision = 4'b0010;
    step();
    startOfFrame = 1'b0;
    slotCollision = '0;
    check("ghost_catch", 32'(caughtValid), 32'd0);
    check("miss_y_f1", 32'(y_at(0)), 32'd429);
    frame();
    check("miss_y_f2", 32'(y_at(0)), 32'd430);
    check("miss_active_f2", 32'(activeMask), 32'b0001);
    frame();
    check("miss_active_f3", 32'(activeMask), 32'd0);
    check("miss_count1", 32'(missCount), 32'd1);
    check("miss_nocatch", 32'(caughtValid), 32'd0);

    // Saturate the miss counter, four misses per frame
    for (int r = 0; r < 65; r++) begin
      for (int s = 0; s < 4; s++) spawn(11'(s * 40), 11'd2000, 2'd1, 1'b0, 1'b1);
      frame();
      if (r == 0)  check("miss_round0", 32'(missCount), 32'd5);
      if (r == 62) check("miss_round62", 32'(missCount), 32'd253);
      if (r == 63) check("miss_sat", 32'(missCount), 32'd255);
    end
    check("miss_sat_hold", 32'(missCount), 32'd255);
    check("miss_sat_active", 32'(activeMask), 32'd0);

    // Asynchronous reset mid-fall
    spawn(11'd60, 11'd100, 2'd1, 1'b0, 1'b1);
    frame();
    check("prereset_active", 32'(activeMask), 32'b0001);
    #3;
    resetN = 1'b0;
    #1;
    check("areset_active", 32'(activeMask), 32'd0);
    check("areset_miss", 32'(missCount), 32'd0);
    check("areset_pos", 32'(|{topLeftX, topLeftY, slotType}), 32'd0);
    step();
    resetN = 1'b1;
    step();
    check("post_reset_active", 32'(activeMask), 32'd0);

    check("catch_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
